// File: rtl/lvds_timing_if.sv
// Config and pixel-source bundle for the LVDS raster sequencer.
// The slave side is the timing controller; the master side offers timing
// and supplies pixel data one cycle after each request.
interface lvds_timing_if #(parameter int CW = 11);
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_error;
   logic [CW-1:0] cfg_h_active;
   logic [CW-1:0] cfg_h_blank;
   logic [CW-1:0] cfg_v_active;
   logic [CW-1:0] cfg_v_blank;
   logic          pix_req;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic [5:0]    pix_red;
   logic [5:0]    pix_green;
   logic [5:0]    pix_blue;

   modport master (
      output cfg_valid, cfg_h_active, cfg_h_blank, cfg_v_active, cfg_v_blank,
      output pix_red, pix_green, pix_blue,
      input  cfg_ready, cfg_error, pix_req, pix_x, pix_y
   );

   modport slave (
      input  cfg_valid, cfg_h_active, cfg_h_blank, cfg_v_active, cfg_v_blank,
      input  pix_red, pix_green, pix_blue,
      output cfg_ready, cfg_error, pix_req, pix_x, pix_y
   );
endinterface

// File: rtl/lvds_timing_controller.sv
// Programmable raster sequencer for the LVDS encoder. Timing registers are
// reloaded only at frame boundaries (or while idle) so a frame is never torn.
// Stage 0 issues pixel requests from the counters; stage 1 registers syncs
// and gates the source data returned one cycle later.
module lvds_timing_controller #(
   parameter int CW       = 11,
   parameter int H_ACTIVE = 1280,
   parameter int H_BLANK  = 192,
   parameter int V_ACTIVE = 800,
   parameter int V_BLANK  = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   lvds_timing_if.slave bus,
   output logic [5:0]   Red,
   output logic [5:0]   Green,
   output logic [5:0]   Blue,
   output logic         HSync,
   output logic         VSync,
   output logic         DataEnable,
   output logic         frame_start,
   output logic         running
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] h_act, h_blk, v_act, v_blk;
   logic [CW-1:0] p_h_act, p_h_blk, p_v_act, p_v_blk;
   logic          pend_full;
   logic [CW-1:0] x, y;
   logic [CW:0]   h_total, v_total, cfg_sum;
   logic          counting, eol, eof, accept, cfg_bad, apply;

   assign h_total  = {1'b0, h_act} + {1'b0, h_blk};
   assign v_total  = {1'b0, v_act} + {1'b0, v_blk};
   assign counting = (state == RUN) || (state == DRAIN);
   assign eol      = ({1'b0, x} == h_total - (CW+1)'(1));
   assign eof      = eol && ({1'b0, y} == v_total - (CW+1)'(1));
   assign running  = counting;

   // An offer is illegal if any field is zero or the line length would not
   // fit in CW bits (carry out of the active+blank sum).
   assign cfg_sum  = {1'b0, bus.cfg_h_active} + {1'b0, bus.cfg_h_blank};
   assign cfg_bad  = (bus.cfg_h_active == '0) || (bus.cfg_h_blank == '0) ||
                     (bus.cfg_v_active == '0) || (bus.cfg_v_blank == '0) ||
                     cfg_sum[CW];
   assign bus.cfg_ready = !pend_full;
   assign accept   = bus.cfg_valid && !pend_full;
   assign apply    = pend_full && ((state == IDLE) || (counting && eof));

   // Stage 0: request the pixel at the current coordinate.
   assign bus.pix_req = counting && (x < h_act) && (y < v_act);
   assign bus.pix_x   = x;
   assign bus.pix_y   = y;

   // Source data arrives in stage 1; blank it outside the active window.
   assign Red   = DataEnable ? bus.pix_red   : 6'd0;
   assign Green = DataEnable ? bus.pix_green : 6'd0;
   assign Blue  = DataEnable ? bus.pix_blue  : 6'd0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: DRAIN finishes the frame, then idles or resumes with no gap.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = RUN;
         RUN:     if (!enable) state_nx = DRAIN;
         DRAIN:   if (eof) state_nx = enable ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Raster counters; held at the origin while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (!counting) begin
         x <= '0;
         y <= '0;
      end else if (eol) begin
         x <= '0;
         y <= eof ? '0 : y + CW'(1);
      end else begin
         x <= x + CW'(1);
      end
   end

   // Pending slot and active timing; accept and apply are mutually
   // exclusive because accept needs the slot empty and apply needs it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_act         <= CW'(H_ACTIVE);
         h_blk         <= CW'(H_BLANK);
         v_act         <= CW'(V_ACTIVE);
         v_blk         <= CW'(V_BLANK);
         p_h_act       <= '0;
         p_h_blk       <= '0;
         p_v_act       <= '0;
         p_v_blk       <= '0;
         pend_full     <= 1'b0;
         bus.cfg_error <= 1'b0;
      end else begin
         bus.cfg_error <= accept && cfg_bad;
         if (accept && !cfg_bad) begin
            p_h_act   <= bus.cfg_h_active;
            p_h_blk   <= bus.cfg_h_blank;
            p_v_act   <= bus.cfg_v_active;
            p_v_blk   <= bus.cfg_v_blank;
            pend_full <= 1'b1;
         end else if (apply) begin
            h_act     <= p_h_act;
            h_blk     <= p_h_blk;
            v_act     <= p_v_act;
            v_blk     <= p_v_blk;
            pend_full <= 1'b0;
         end
      end
   end

   // Stage 1: syncs and data enable delayed to line up with returned data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DataEnable  <= 1'b0;
         HSync       <= 1'b1;
         VSync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         DataEnable  <= bus.pix_req;
         HSync       <= !(counting && (x >= h_act));
         VSync       <= !(counting && (y >= v_act));
         frame_start <= counting && (x == '0) && (y == '0);
      end
   end

endmodule

// File: tb/tb_lvds_timing_controller.sv
// Scoreboard bench for lvds_timing_controller: stimulus pushes expected
// per-cycle output snapshots (with a field mask); the monitor compares each
// one on the falling edge of the cycle it names.
module tb_lvds_timing_controller;
   localparam int CW = 11;

   // Snapshot layout: {req, err, rdy, run, fs, vs, hs, de, green[5:0], red[5:0]}
   localparam logic [19:0] MK_RGB  = 20'h00FFF;
   localparam logic [19:0] MK_DE   = 20'h01000;
   localparam logic [19:0] MK_FS   = 20'h08000;
   localparam logic [19:0] MK_RUN  = 20'h10000;
   localparam logic [19:0] MK_RDY  = 20'h20000;
   localparam logic [19:0] MK_ERR  = 20'h40000;
   localparam logic [19:0] MK_REQ  = 20'h80000;
   localparam logic [19:0] MK_OUT  = 20'h0FFFF;
   localparam logic [19:0] MK_IDLE = 20'h9FFFF;
   localparam logic [19:0] EV_IDLE = 20'h06000;

   typedef struct {
      int          cyc;
      logic [19:0] mk;
      logic [19:0] ev;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   logic [5:0] Red, Green, Blue;
   logic HSync, VSync, DataEnable, frame_start, running;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   exp_t q[$];

   lvds_timing_if #(.CW(CW)) bus();

   lvds_timing_controller #(.CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
      .Red(Red), .Green(Green), .Blue(Blue),
      .HSync(HSync), .VSync(VSync), .DataEnable(DataEnable),
      .frame_start(frame_start), .running(running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pixel source: one-cycle latency, red = x, green = y.
   always @(posedge clk) begin
      bus.pix_red   <= bus.pix_x[5:0];
      bus.pix_green <= bus.pix_y[5:0];
      bus.pix_blue  <= ~bus.pix_x[5:0];
   end

   // Monitor: compare every expectation due this cycle, flag any missed.
   always @(negedge clk) begin
      logic [19:0] act;
      act = {bus.pix_req, bus.cfg_error, bus.cfg_ready, running, frame_start,
             VSync, HSync, DataEnable, Green, Red};
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            n_run++;
            if (((act ^ q[i].ev) & q[i].mk) != 20'h0) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got %05h want %05h (mask %05h)",
                        q[i].name, cyc, act & q[i].mk, q[i].ev & q[i].mk, q[i].mk);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            n_run++;
            n_fail++;
            $display("FAIL %s @cyc %0d: not sampled, want %05h", q[i].name, q[i].cyc, q[i].ev);
            q.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got cyc %0d want < 20000", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic push(input int c, input string nm, input logic [19:0] mk, input logic [19:0] ev);
      exp_t e;
      e.cyc = c; e.mk = mk; e.ev = ev; e.name = nm;
      q.push_back(e);
   endtask

   task automatic set_cfg(input int ha, input int hb, input int va, input int vb);
      bus.cfg_h_active = CW'(ha);
      bus.cfg_h_blank  = CW'(hb);
      bus.cfg_v_active = CW'(va);
      bus.cfg_v_blank  = CW'(vb);
      bus.cfg_valid    = 1'b1;
   endtask

   // Expected outputs for a frame whose pixel (0,0) appears at cycle start.
   task automatic expect_frame(input int start, input int ha, input int hb,
                               input int va, input int vb, input int n, input string nm);
      int ht, tot, lim, x, y;
      logic hs, vs, de, fs;
      logic [5:0] r, g;
      logic [19:0] mk;
      ht  = ha + hb;
      tot = ht * (va + vb);
      lim = (n < tot) ? n : tot;
      for (int k = 0; k < lim; k++) begin
         x  = k % ht;
         y  = k / ht;
         hs = (x < ha);
         vs = (y < va);
         de = hs && vs;
         fs = (k == 0);
         r  = de ? 6'(x) : 6'd0;
         g  = de ? 6'(y) : 6'd0;
         mk = MK_OUT | ((k < tot - 1) ? MK_RUN : 20'h0);
         push(start + k, $sformatf("%s k=%0d", nm, k), mk,
              {1'b0, 1'b0, 1'b0, 1'b1, fs, vs, hs, de, g, r});
      end
   endtask

   initial begin
      int b, nxt, f2, f3, f4, f5, f6, f7, f8, e, r, s;
      rst_n = 1'b0;
      enable = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_h_active = '0; bus.cfg_h_blank = '0;
      bus.cfg_v_active = '0; bus.cfg_v_blank = '0;
      repeat (3) tick();
      push(cyc, "reset", MK_IDLE | MK_RDY | MK_ERR, EV_IDLE | MK_RDY);
      rst_n = 1'b1;
      tick();

      // Load 8/4/3/2 while idle: slot busy one cycle, then applied.
      set_cfg(8, 4, 3, 2);
      tick();
      bus.cfg_valid = 1'b0;
      push(cyc, "cfg_idle_busy", MK_RDY, 20'h0);
      push(cyc + 1, "cfg_idle_done", MK_RDY, MK_RDY);
      tick(); tick();

      // Start: request on first RUN cycle, DataEnable one cycle later.
      enable = 1'b1;
      b = cyc;
      push(b + 1, "first_req", MK_REQ | MK_DE | MK_RUN, MK_REQ | MK_RUN);
      nxt = b + 2;
      expect_frame(nxt, 8, 4, 3, 2, 1000, "frame1");
      nxt += 60;
      f2 = nxt;
      expect_frame(f2, 8, 4, 3, 2, 1000, "frame2");
      nxt += 60;

      // Mid-frame reload to h_active=4: held pending until EOF.
      wait_until(f2 + 19);
      set_cfg(4, 4, 3, 2);
      tick();
      bus.cfg_valid = 1'b0;
      push(cyc, "cfg_mid_busy", MK_RDY, 20'h0);
      push(f2 + 58, "cfg_eof_busy", MK_RDY, 20'h0);
      push(f2 + 59, "cfg_eof_ready", MK_RDY, MK_RDY);
      f3 = nxt;
      expect_frame(f3, 4, 4, 3, 2, 1000, "frame3");
      nxt += 40;

      // Illegal config (v_blank=0): error pulse, slot stays free.
      wait_until(f3 + 10);
      set_cfg(4, 4, 3, 0);
      tick();
      bus.cfg_valid = 1'b0;
      push(cyc, "cfg_reject_err", MK_ERR | MK_RDY, MK_ERR | MK_RDY);
      push(cyc + 1, "cfg_reject_clr", MK_ERR | MK_RDY, MK_RDY);
      f4 = nxt;
      expect_frame(f4, 4, 4, 3, 2, 1000, "frame4");
      nxt += 40;

      // Drop enable at line 1, raise before EOF: seamless next frame.
      wait_until(f4 + 7);
      enable = 1'b0;
      f5 = nxt;
      expect_frame(f5, 4, 4, 3, 2, 1000, "frame5");
      push(f5 - 1, "drain_resume_run", MK_RUN, MK_RUN);
      nxt += 40;
      wait_until(f4 + 20);
      enable = 1'b1;
      f6 = nxt;
      expect_frame(f6, 4, 4, 3, 2, 1000, "frame6");
      nxt += 40;

      // Drop enable for good, with a pending config: idle and apply at EOF.
      wait_until(f6 + 7);
      enable = 1'b0;
      wait_until(f6 + 15);
      set_cfg(8, 4, 3, 2);
      tick();
      bus.cfg_valid = 1'b0;
      push(cyc, "cfg_drain_busy", MK_RDY, 20'h0);
      e = f6 + 38;
      push(e + 1, "eof_to_idle", MK_RUN | MK_REQ | MK_RDY, MK_RDY);
      push(e + 2, "idle_out_a", MK_IDLE | MK_RDY, EV_IDLE | MK_RDY);
      push(e + 3, "idle_out_b", MK_IDLE | MK_RDY, EV_IDLE | MK_RDY);

      // Restart: applied 8/4/3/2 timing, then reset mid-line with slot full.
      wait_until(e + 5);
      enable = 1'b1;
      f7 = cyc + 2;
      expect_frame(f7, 8, 4, 3, 2, 1000, "frame7");
      f8 = f7 + 60;
      r  = f8 + 17;
      expect_frame(f8, 8, 4, 3, 2, r - f8, "frame8");
      wait_until(f8 + 5);
      set_cfg(4, 4, 3, 2);
      tick();
      bus.cfg_valid = 1'b0;
      push(cyc, "cfg_pre_rst_busy", MK_RDY, 20'h0);
      wait_until(r);
      rst_n = 1'b0;
      enable = 1'b0;
      push(r, "rst_immediate", MK_IDLE | MK_RDY | MK_ERR, EV_IDLE | MK_RDY);
      tick();
      push(cyc, "rst_held", MK_IDLE | MK_RDY, EV_IDLE | MK_RDY);
      rst_n = 1'b1;
      tick();

      // Default 1280/192 timing after reset (pending config was lost).
      enable = 1'b1;
      s = cyc + 2;
      push(s,        "dflt_x0",    MK_OUT, 20'h0F000);
      push(s + 1279, "dflt_x1279", MK_OUT, 20'h0703F);
      push(s + 1280, "dflt_x1280", MK_OUT, 20'h04000);
      push(s + 1471, "dflt_x1471", MK_OUT, 20'h04000);
      push(s + 1472, "dflt_line1", MK_OUT, 20'h07040);
      wait_until(s + 1480);

      foreach (q[i]) begin
         n_run++;
         n_fail++;
         $display("FAIL %s: pending at end, want cyc %0d", q[i].name, q[i].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/lvds_timing_controller.md
Name: lvds_timing_controller

Overview:
Programmable raster sequencer that drives the HSync/VSync/DataEnable/RGB inputs of the LVDS video encoder on the dot clock. It replaces fixed-constant sync counting with run-time timing registers. New timing is loaded through a valid/ready config port and applied only at frame boundaries, so the panel never sees a torn frame. It requests pixels from a pattern or framebuffer source by coordinate and aligns the returned data with the sync outputs.

Parameters:
CW, 11, width of all coordinate counters and timing fields
H_ACTIVE, 1280, reset value of active pixels per line
H_BLANK, 192, reset value of horizontal blanking cycles
V_ACTIVE, 800, reset value of active lines per frame
V_BLANK, 12, reset value of vertical blanking lines

Ports:
clk  in  1  dot clock (encoder DotClock domain)
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; level sensitive
cfg_valid  in  1  new timing offered
cfg_ready  out  1  pending slot empty
cfg_h_active, cfg_h_blank, cfg_v_active, cfg_v_blank  in  CW each  offered timing
cfg_error  out  1  one-cycle pulse: offered config rejected
pix_req  out  1  pixel wanted for pix_x/pix_y (combinational from counters)
pix_x, pix_y  out  CW  requested coordinate
pix_red, pix_green, pix_blue  in  6 each  source data, valid 1 cycle after pix_req
Red, Green, Blue  out  6 each  to encoder
HSync, VSync  out  1  active-low syncs to encoder
DataEnable  out  1  to encoder
frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)
running  out  1  high in RUN or DRAIN

Behaviour:
- Reset: state IDLE; active timing = parameter defaults; pending empty; counters 0; HSync=1, VSync=1, DataEnable=0, RGB=0, frame_start=0, cfg_error=0, cfg_ready=1, running=0.
- Counters: x in 0..h_total-1, h_total = h_active+h_blank; y in 0..v_total-1. Sums are CW+1 bits; no overflow possible at CW=11 with legal values. x wraps to 0 and y increments at x==h_total-1; y wraps at y==v_total-1 (end of frame, EOF).
- Stage 0 (counter cycle N): pix_req = RUN/DRAIN && x<h_active && y<v_active; pix_x=x, pix_y=y.
- Stage 1 (N+1, registered): DataEnable = delayed pix_req; HSync = 0 when delayed x>=h_active, else 1; VSync = 0 when delayed y>=v_active, else 1; RGB = pix_* when DataEnable is high, else 0. Total latency counter to outputs: 1 cycle.
- Config: handshake completes when cfg_valid && cfg_ready. If any field is 0, or h_active>2^CW-1-h_blank, the config is discarded, cfg_error pulses the next cycle, and pending stays empty. Otherwise it is latched into pending and cfg_ready drops. Pending is copied to active either at EOF (the next cycle starts frame 0 with the new values) or immediately in IDLE. cfg_ready rises the cycle after the copy.
- States:
  - IDLE: counters held at 0; outputs at idle values. enable=1 -> RUN, with x=y=0 on the first RUN cycle.
  - RUN: counting. enable=0 -> DRAIN.
  - DRAIN: counting continues. At EOF -> IDLE if enable=0; -> RUN if enable has returned to 1 (no gap inserted).
- frame_start: asserted in stage 1 when the delayed (x,y)==(0,0) in RUN/DRAIN.
- Simultaneous cases:
  - Handshake on the EOF cycle: the new config goes to pending, not active; it is applied at the next EOF.
  - EOF with enable=0 and pending full: go to IDLE and apply pending.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); pending config is lost.

Test Plan:
- Reset, enable=1, cfg H_ACTIVE=8/H_BLANK=4/V_ACTIVE=3/V_BLANK=2 loaded in IDLE -> first DataEnable 1 cycle after first pix_req; line period 12 cycles; HSync low 4 cycles per line; VSync low for lines 3-4; frame period 60 cycles; frame_start every 60 cycles.
- Source returns pix_red=pix_x[5:0] -> Red equals the x of the previous cycle during DataEnable, and 0 during blanking.
- Mid-frame cfg (h_active=4) -> cfg_ready low until EOF; current frame finishes at 12-cycle lines; next frame has 8-cycle lines; cfg_ready high 1 cycle after EOF.
- cfg with v_blank=0 -> cfg_error pulses once, cfg_ready stays 1, timing unchanged.
- enable dropped at line 1, then raised before EOF -> frame completes, the next frame starts with no gap, and running never drops. Same sequence without raising -> IDLE after EOF, outputs idle, running=0.
- rst_n asserted mid-line with pending full -> outputs return to idle values immediately, cfg_ready=1; after release, timing uses the parameter defaults.
